// File: rtl/cmp_config_parser.sv
// rtl/cmp_config_parser.sv - comparator config packet parser; optional checksum via CMP_CONFIG_CHECKSUM_EN
`timescale 1ns/1ps
module cmp_config_parser #(
    parameter int HASH_NUM_MSB   = 8,
    parameter int HASH_COUNT_MSB = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              din,
    input  logic                    empty,
    output logic                    rd_en,
    input  logic                    cmp_busy,
    output logic [7:0]              cmp_din,
    output logic                    cmp_wr_en,
    output logic [HASH_NUM_MSB+2:0] cmp_wr_addr,
    output logic [HASH_COUNT_MSB:0] hash_count,
    output logic                    config_valid,
    output logic                    error
);

    localparam int NW = HASH_NUM_MSB + 1;
    localparam int AW = HASH_NUM_MSB + 3;
    localparam int CW = HASH_COUNT_MSB + 1;
    localparam logic [16:0] NMAX = 17'(1) << NW;

    localparam logic [2:0] S_HDR0  = 3'd0;
    localparam logic [2:0] S_HDR1  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;
`ifdef CMP_CONFIG_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd6;
`endif

    logic [2:0]    state;
    logic [7:0]    n_lo;
    logic [NW-1:0] n_m1;
    logic [AW-1:0] byte_cnt;
    logic          accepting;
    logic [16:0]   n_hdr;
    logic [NW-1:0] n_m1_next;
    logic          last_byte;
`ifdef CMP_CONFIG_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // Decide whether the current state consumes FIFO bytes and derive header/counter helpers
    always_comb begin
        accepting = 1'b0;
        case (state)
            S_HDR0, S_HDR1, S_DATA, S_END: accepting = 1'b1;
`ifdef CMP_CONFIG_CHECKSUM_EN
            S_CSUM:                        accepting = 1'b1;
`endif
            default:                       accepting = 1'b0;
        endcase
        rd_en     = accepting && !empty && !RST;
        n_hdr     = {1'b0, din, n_lo};
        n_m1_next = NW'(n_hdr - 17'd1);
        last_byte = (byte_cnt == {n_m1, 2'b11});
    end

    // Packet FSM, memory write pipeline and committed-configuration registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_HDR0;
            n_lo         <= 8'h00;
            n_m1         <= '0;
            byte_cnt     <= '0;
            cmp_din      <= 8'h00;
            cmp_wr_en    <= 1'b0;
            cmp_wr_addr  <= '0;
            hash_count   <= '0;
            config_valid <= 1'b0;
            error        <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
            csum         <= 8'h00;
`endif
        end else begin
            cmp_wr_en <= 1'b0;
            case (state)
                S_HDR0: begin
                    if (rd_en) begin
                        n_lo  <= din;
                        state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (rd_en) begin
                        config_valid <= 1'b0;
                        if (n_hdr == 17'd0 || n_hdr > NMAX) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            n_m1  <= n_m1_next;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cmp_busy) begin
                        byte_cnt <= '0;
`ifdef CMP_CONFIG_CHECKSUM_EN
                        csum     <= 8'h00;
`endif
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_en) begin
                        cmp_wr_en   <= 1'b1;
                        cmp_din     <= din;
                        cmp_wr_addr <= byte_cnt;
`ifdef CMP_CONFIG_CHECKSUM_EN
                        csum        <= csum ^ din;
`endif
                        // Counter stops on the last byte so it never wraps back to 0
                        if (last_byte) begin
`ifdef CMP_CONFIG_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_END;
`endif
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
`ifdef CMP_CONFIG_CHECKSUM_EN
                S_CSUM: begin
                    if (rd_en) begin
                        if (din != csum) begin
                            state        <= S_ERROR;
                            error        <= 1'b1;
                            config_valid <= 1'b0;
                        end else begin
                            state <= S_END;
                        end
                    end
                end
`endif
                S_END: begin
                    if (rd_en) begin
                        if (din != 8'hCC) begin
                            state        <= S_ERROR;
                            error        <= 1'b1;
                            config_valid <= 1'b0;
                        end else begin
                            hash_count   <= CW'(n_m1);
                            config_valid <= 1'b1;
                            state        <= S_HDR0;
                        end
                    end
                end
                S_ERROR: begin
                    error        <= 1'b1;
                    config_valid <= 1'b0;
                end
                default: state <= S_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_config_parser.sv
// tb/tb_cmp_config_parser.sv - directed-vector bench for cmp_config_parser
`timescale 1ns/1ps
module tb_cmp_config_parser;

`ifdef CMP_CONFIG_CHECKSUM_EN
    localparam int CSB = 1;
`else
    localparam int CSB = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  din = 8'h00;
    logic        empty = 1'b1;
    logic        rd_en;
    logic        cmp_busy;
    logic [7:0]  cmp_din;
    logic        cmp_wr_en;
    logic [10:0] cmp_wr_addr;
    logic [8:0]  hash_count;
    logic        config_valid;
    logic        error;

    cmp_config_parser #(.HASH_NUM_MSB(8), .HASH_COUNT_MSB(8)) dut (
        .CLK(CLK), .RST(RST), .din(din), .empty(empty), .rd_en(rd_en),
        .cmp_busy(cmp_busy), .cmp_din(cmp_din), .cmp_wr_en(cmp_wr_en),
        .cmp_wr_addr(cmp_wr_addr), .hash_count(hash_count),
        .config_valid(config_valid), .error(error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    logic [7:0] fifo_q[$];
    bit         hold_empty;
    bit         will_pop = 1'b0;
    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         wr_cyc_q[$];
    int         pop_cyc_q[$];
    int         cv_rise_cnt, cv_rise_cyc, cv_fall_cyc, err_rise_cyc;
    logic       cv_prev = 1'b0;
    logic       err_prev = 1'b0;
    logic [7:0] csum_acc;
    int         vectors = 0;
    int         miscompares = 0;

    // FIFO model and output monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (will_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        din   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        empty = (fifo_q.size() == 0) || hold_empty;
        if (cmp_wr_en) begin
            wr_addr_q.push_back(int'(cmp_wr_addr));
            wr_data_q.push_back(int'(cmp_din));
            wr_cyc_q.push_back(cyc);
        end
        if (config_valid && !cv_prev) begin
            cv_rise_cnt++;
            cv_rise_cyc = cyc;
        end
        if (!config_valid && cv_prev) cv_fall_cyc = cyc;
        if (error && !err_prev) err_rise_cyc = cyc;
        cv_prev  = config_valid;
        err_prev = error;
        #1;
        will_pop = rd_en;
        if (will_pop) pop_cyc_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qi(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pop_cyc_q.delete();
        cv_rise_cnt  = 0;
        cv_rise_cyc  = -1;
        cv_fall_cyc  = -1;
        err_rise_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        #3;
        fifo_q.delete();
        clear_logs();
        hold_empty = 1'b0;
        cmp_busy   = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
    endtask

    task automatic push_hdr(input int n);
        fifo_q.push_back(n[7:0]);
        fifo_q.push_back(n[15:8]);
        csum_acc = 8'h00;
    endtask

    task automatic push_data(input logic [7:0] b);
        fifo_q.push_back(b);
        csum_acc = csum_acc ^ b;
    endtask

    task automatic push_tail(input logic [7:0] term);
`ifdef CMP_CONFIG_CHECKSUM_EN
        fifo_q.push_back(csum_acc);
`endif
        fifo_q.push_back(term);
    endtask

    // kind 1: config_valid rises arg times; 2: error set; 3: arg writes seen
    task automatic wait_for(input int kind, input int arg, input int max_cyc, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge CLK);
            #2;
            case (kind)
                1:       done = (cv_rise_cnt >= arg);
                2:       done = (error === 1'b1);
                3:       done = (wr_addr_q.size() >= arg);
                default: done = 1'b1;
            endcase
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int bad;
        int c0;
        int n;
        RST = 1'b1;
        cmp_busy = 1'b0;
        hold_empty = 1'b0;
        csum_acc = 8'h00;
        clear_logs();

        // Reset values with a non-empty FIFO held off by reset
        fifo_q.push_back(8'h5A);
        repeat (3) @(posedge CLK);
        #2;
        check_eq("rst_rd_en",        32'(rd_en),        32'd0);
        check_eq("rst_cmp_din",      32'(cmp_din),      32'd0);
        check_eq("rst_cmp_wr_en",    32'(cmp_wr_en),    32'd0);
        check_eq("rst_cmp_wr_addr",  32'(cmp_wr_addr),  32'd0);
        check_eq("rst_hash_count",   32'(hash_count),   32'd0);
        check_eq("rst_config_valid", 32'(config_valid), 32'd0);
        check_eq("rst_error",        32'(error),        32'd0);
        fifo_q.delete();
        @(posedge CLK);
        #2 RST = 1'b0;

        // N=2 load, FIFO always full
        clear_logs();
        push_hdr(2);
        for (int i = 0; i < 8; i++) push_data(8'((i + 1) * 17));
        push_tail(8'hCC);
        wait_for(1, 1, 100, "t1");
        check_eq("t1_nwr",  32'(wr_addr_q.size()), 32'd8);
        check_eq("t1_npop", 32'(pop_cyc_q.size()), 32'(2 + 8 + CSB + 1));
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != (i + 1) * 17) bad++;
        check_eq("t1_addr_data", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < wr_cyc_q.size(); i++)
            if (wr_cyc_q[i] != wr_cyc_q[0] + i) bad++;
        check_eq("t1_consecutive", 32'(bad), 32'd0);
        check_eq("t1_wr_latency", 32'(qi(wr_cyc_q, 0)), 32'(qi(pop_cyc_q, 2) + 1));
        check_eq("t1_cv_rise",    32'(cv_rise_cyc), 32'(qi(pop_cyc_q, pop_cyc_q.size() - 1) + 1));
        check_eq("t1_hash_count", 32'(hash_count), 32'd1);
        check_eq("t1_cv",         32'(config_valid), 32'd1);

        // New packet over a valid config, comparator busy after the header
        clear_logs();
        cmp_busy = 1'b1;
        push_hdr(1);
        push_data(8'hA1); push_data(8'hB2); push_data(8'hC3); push_data(8'hD4);
        push_tail(8'hCC);
        repeat (10) @(posedge CLK);
        #2;
        check_eq("t2_busy_rd_en", 32'(rd_en), 32'd0);
        check_eq("t2_busy_npop",  32'(pop_cyc_q.size()), 32'd2);
        check_eq("t2_busy_nwr",   32'(wr_addr_q.size()), 32'd0);
        check_eq("t2_cv_low",     32'(config_valid), 32'd0);
        check_eq("t2_cv_fall",    32'(cv_fall_cyc), 32'(qi(pop_cyc_q, 1) + 1));
        c0 = cyc;
        cmp_busy = 1'b0;
        wait_for(1, 1, 50, "t2");
        check_eq("t2_first_pop", 32'(qi(pop_cyc_q, 2)), 32'(c0 + 1));
        check_eq("t2_first_wr",  32'(qi(wr_cyc_q, 0)),  32'(c0 + 2));
        check_eq("t2_nwr",       32'(wr_addr_q.size()), 32'd4);
        check_eq("t2_last_data", 32'(qi(wr_data_q, 3)), 32'h0D4);
        check_eq("t2_hash_count", 32'(hash_count), 32'd0);

        // Full-capacity load
        do_reset();
        push_hdr(512);
        for (int k = 0; k < 2048; k++) push_data(8'(k));
        push_tail(8'hCC);
        wait_for(1, 1, 2400, "t3");
        check_eq("t3_nwr", 32'(wr_addr_q.size()), 32'd2048);
        check_eq("t3_last_addr", 32'(qi(wr_addr_q, wr_addr_q.size() - 1)), 32'd2047);
        bad = 0;
        c0 = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != i || wr_data_q[i] != (i & 255)) bad++;
            if (wr_addr_q[i] == 0) c0++;
        end
        check_eq("t3_addr_data", 32'(bad), 32'd0);
        check_eq("t3_addr0_once", 32'(c0), 32'd1);
        check_eq("t3_hash_count", 32'(hash_count), 32'd511);
        check_eq("t3_cv", 32'(config_valid), 32'd1);

        // Illegal header counts
        for (int t = 0; t < 2; t++) begin
            n = (t == 0) ? 0 : 513;
            do_reset();
            push_hdr(n);
            push_data(8'h11);
            push_data(8'h22);
            wait_for(2, 0, 20, $sformatf("hdr%0d", n));
            repeat (3) @(posedge CLK);
            #2;
            check_eq($sformatf("hdr%0d_error", n), 32'(error), 32'd1);
            check_eq($sformatf("hdr%0d_cv", n),    32'(config_valid), 32'd0);
            check_eq($sformatf("hdr%0d_rd_en", n), 32'(rd_en), 32'd0);
            check_eq($sformatf("hdr%0d_nwr", n),   32'(wr_addr_q.size()), 32'd0);
            check_eq($sformatf("hdr%0d_npop", n),  32'(pop_cyc_q.size()), 32'd2);
            check_eq($sformatf("hdr%0d_err_t", n), 32'(err_rise_cyc), 32'(qi(pop_cyc_q, 1) + 1));
        end

        // Bad terminator
        do_reset();
        push_hdr(1);
        push_data(8'hAA); push_data(8'hBB); push_data(8'hCC); push_data(8'hDD);
        push_tail(8'hCD);
        push_data(8'h55);
        wait_for(2, 0, 30, "t5");
        repeat (2) @(posedge CLK);
        #2;
        check_eq("t5_nwr",   32'(wr_addr_q.size()), 32'd4);
        check_eq("t5_error", 32'(error), 32'd1);
        check_eq("t5_cv",    32'(config_valid), 32'd0);
        check_eq("t5_npop",  32'(pop_cyc_q.size()), 32'(2 + 4 + CSB + 1));
        check_eq("t5_err_t", 32'(err_rise_cyc), 32'(qi(pop_cyc_q, pop_cyc_q.size() - 1) + 1));

        // Reset mid-DATA, then a fresh packet with an empty-FIFO stall
        do_reset();
        push_hdr(4);
        push_data(8'h01); push_data(8'h02); push_data(8'h03);
        wait_for(3, 3, 30, "t6_part");
        do_reset();
        push_hdr(1);
        push_data(8'hDE); push_data(8'hAD);
        repeat (5) @(posedge CLK);
        #2;
        push_data(8'hBE); push_data(8'hEF);
        push_tail(8'hCC);
        wait_for(1, 1, 50, "t6");
        check_eq("t6_nwr", 32'(wr_addr_q.size()), 32'd4);
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] != i) bad++;
        check_eq("t6_addr", 32'(bad), 32'd0);
        check_eq("t6_data0", 32'(qi(wr_data_q, 0)), 32'h0DE);
        check_eq("t6_data3", 32'(qi(wr_data_q, 3)), 32'h0EF);
        check_eq("t6_hash_count", 32'(hash_count), 32'd0);
        check_eq("t6_cv", 32'(config_valid), 32'd1);
        check_eq("t6_error", 32'(error), 32'd0);

`ifdef CMP_CONFIG_CHECKSUM_EN
        // Wrong checksum byte: 10^20^30^40 = 40, send 41
        do_reset();
        push_hdr(1);
        push_data(8'h10); push_data(8'h20); push_data(8'h30); push_data(8'h40);
        fifo_q.push_back(8'h41);
        fifo_q.push_back(8'hCC);
        wait_for(2, 0, 30, "t7");
        check_eq("t7_error", 32'(error), 32'd1);
        check_eq("t7_nwr",   32'(wr_addr_q.size()), 32'd4);
        check_eq("t7_cv",    32'(config_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmp_config_parser.md
# cmp_config_parser

Parses the comparator configuration packet from the input byte FIFO and loads hash words into the comparator's byte-wide memory. It drives the comparator's `din` / `wr_en` / `wr_addr` / `hash_count` inputs and tells the arbiter when a valid configuration is loaded. It also blocks memory writes while a comparison is in progress.

## Interface
- `HASH_NUM_MSB`, 8: MSB of hash index; capacity `NMAX = 2^(HASH_NUM_MSB+1)` hashes (512).
- `HASH_COUNT_MSB`, 8: MSB of the `hash_count` output.
- `CLK`  in  1: clock.
- `RST`  in  1: asynchronous, active-high reset.
- `din`  in  8: packet byte from the first-word-fall-through FIFO.
- `empty`  in  1: FIFO empty.
- `rd_en`  out  1: pops `din`; combinational, equals `!empty && accepting`.
- `cmp_busy`  in  1: comparator is between `start` and `found`/`finished`.
- `cmp_din`  out  8: byte to comparator memory.
- `cmp_wr_en`  out  1: write strobe.
- `cmp_wr_addr`  out  `HASH_NUM_MSB+3`: byte address; byte `k` of the hash list goes to address `k`.
- `hash_count`  out  `HASH_COUNT_MSB+1`: N-1 for the committed configuration.
- `config_valid`  out  1: a committed configuration is present.
- `error`  out  1: sticky packet error, cleared only by `RST`.

## Operation
- Packet format:
  - `N_lo`, `N_hi`: N is 16-bit little-endian.
  - N×4 hash bytes: each 32-bit word is little-endian.
  - [checksum]: present only with the macro.
  - Terminator `0xCC`.
- States:
  - **HDR0**: accept `N_lo` → HDR1.
  - **HDR1**: accept `N_hi`.
    - If N==0 or N>NMAX → ERROR.
    - Else deassert `config_valid` and go → WAIT.
  - **WAIT**: `rd_en`=0. When `cmp_busy`==0, clear the byte counter → DATA.
  - **DATA**: accept a byte each cycle FIFO is non-empty and write it at the counter address; counter +1. After byte 4N-1 → END (or CSUM).
  - **CSUM** (macro only): accept 1 byte; if it ≠ XOR of all hash bytes → ERROR, else → END.
  - **END**: accept 1 byte.
    - If ≠ `0xCC` → ERROR.
    - Else load `hash_count` ← N-1 (truncated to width), set `config_valid` → HDR0.
  - **ERROR**: `rd_en`=0, `error`=1, `config_valid`=0. Terminal until `RST`.
- `rd_en` is 0 in WAIT and ERROR.
- Byte counter is `HASH_NUM_MSB+3` bits. It never wraps, because N≤NMAX bounds it to 4·NMAX-1.
- `cmp_busy` rising during DATA does not pause writes. The arbiter must not start the comparator while `config_valid`=0; this is the caller's obligation.
- A new packet while `config_valid`=1 is legal: the previous configuration is invalidated at HDR1.

## Timing
- Reset values: `rd_en`=0, `cmp_din`=0, `cmp_wr_en`=0, `cmp_wr_addr`=0, `hash_count`=0, `config_valid`=0, `error`=0, state HDR0.
- `RST` mid-packet: FSM returns to HDR0. Partially written memory is abandoned; the next packet overwrites it.
- Write latency: byte popped in cycle t → `cmp_wr_en`=1 with `cmp_din`/`cmp_wr_addr` registered in cycle t+1. `cmp_wr_en` is 0 in all other cycles.
- Throughput: 1 byte/cycle in DATA with a non-empty FIFO. `empty` stalls without gaps in addressing.
- `config_valid` timing:
  - Rises the cycle after the terminator pop.
  - The last data write (t+1) precedes the terminator, so memory is complete before `config_valid`=1.
  - Falls the cycle after the `N_hi` pop.
- WAIT exit: first DATA pop at the earliest one cycle after `cmp_busy` is sampled 0.
- `error`: rises the cycle after the offending pop; no further pops.

## Configuration
- `CMP_CONFIG_CHECKSUM_EN` defined:
  - CSUM state present.
  - Packet carries an XOR-of-hash-bytes checksum before the terminator.
  - A mismatch sets `error`.
- Undefined: no CSUM state, no checksum byte; packet is 2+4N+1 bytes.

## Test plan
- Load N=2 {`02 00`, `11 22 33 44`, `55 66 77 88`, `CC`}, FIFO always full:
  - Writes at addr 0..7 with bytes `11`..`88` on consecutive cycles.
  - `hash_count`=1, `config_valid`=1 one cycle after the `CC` pop.
- N=512 full load: last write at addr 2047; `hash_count`=511; no wrap to addr 0.
- Header N=0, and separately N=513: `error`=1 after the `N_hi` pop, `rd_en` held 0, zero writes.
- Bad terminator `0xCD` after N=1: 4 writes occur, then `error`=1 and `config_valid`=0.
- `cmp_busy`=1 for 10 cycles after the header: `rd_en`=0 and no writes during that window; the first write follows `cmp_busy` falling.
- Assert `RST` mid-DATA (after 3 bytes of N=4), then send a fresh N=1 packet: writes restart at addr 0 and `hash_count`=0. With the macro defined, a wrong checksum byte sets `error`.
